clause_solution_checker: RTL

Hardware reader and evaluator for the Clause_Table, the on-chip counterpart to the host-side clause-check loop run after `done_signal`. After the solver finishes, it streams clauses out of the Clause_Table read port, one per cycle. It evaluates each clause against the solver's `vtc_value_bits` assignment bus. It reports overall SAT, the number of unsatisfied clauses, and the address of the first unsatisfied clause.

---
 rtl/clause_solution_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/clause_solution_checker.sv
// Streams clauses from the Clause_Table and checks them against the variable assignment.
// Optional macro CLAUSE_CHECK_EARLY_EXIT_EN: stop at the first unsatisfied clause.
module clause_solution_checker #(
  parameter int NSAT                   = 3,
  parameter int NUM_VARIABLES          = 2048,
  parameter int VARIABLE_ADDRESS_WIDTH = $clog2(NUM_VARIABLES),
  parameter int LITERAL_ADDRESS_WIDTH  = VARIABLE_ADDRESS_WIDTH + 1,
  parameter int NUM_CLAUSES            = 8192,
  parameter int CLAUSE_ADDRESS_WIDTH   = $clog2(NUM_CLAUSES),
  parameter int CLAUSE_WIDTH           = NSAT * LITERAL_ADDRESS_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [CLAUSE_ADDRESS_WIDTH:0]   num_clauses_i,
  input  logic [NUM_VARIABLES-1:0]        value_bits_i,
  output logic                            clause_rd_en_o,
  output logic [CLAUSE_ADDRESS_WIDTH-1:0] clause_rd_addr_o,
  input  logic [CLAUSE_WIDTH-1:0]         clause_rd_data_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            sat_o,
  output logic [CLAUSE_ADDRESS_WIDTH:0]   unsat_count_o,
  output logic                            first_unsat_valid_o,
  output logic [CLAUSE_ADDRESS_WIDTH-1:0] first_unsat_addr_o,
  output logic                            range_err_o
);

  localparam int VAW = VARIABLE_ADDRESS_WIDTH;
  localparam int LAW = LITERAL_ADDRESS_WIDTH;
  localparam int CAW = CLAUSE_ADDRESS_WIDTH;
  localparam logic [CAW:0] ONE       = (CAW+1)'(1);
  localparam logic [CAW:0] TWO       = (CAW+1)'(2);
  localparam logic [CAW:0] MAX_COUNT = (CAW+1)'(NUM_CLAUSES);
  localparam logic [VAW:0] VAR_LIMIT = (VAW+1)'(NUM_VARIABLES);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t           state_reg;
  logic [CAW:0]     n_reg;
  logic             eval_valid_reg;
  logic [CAW-1:0]   eval_addr_reg;
  logic [CAW:0]     n_clamped;
  logic [NSAT-1:0]  lit_val;
  logic [NSAT-1:0]  lit_oob;
  logic             clause_unsat;

  assign n_clamped = (num_clauses_i > MAX_COUNT) ? MAX_COUNT : num_clauses_i;

  // Out-of-range variables evaluate false and never index the assignment bus.
  genvar gi;
  generate
    for (gi = 0; gi < NSAT; gi++) begin : g_lit
      logic [LAW-1:0] lit;
      assign lit         = clause_rd_data_i[gi*LAW +: LAW];
      assign lit_oob[gi] = {1'b0, lit[VAW-1:0]} >= VAR_LIMIT;
      assign lit_val[gi] = !lit_oob[gi] && (value_bits_i[lit[VAW-1:0]] ^ lit[LAW-1]);
    end
  endgenerate

  assign clause_unsat = !(|lit_val);

`ifdef CLAUSE_CHECK_EARLY_EXIT_EN
  logic first_hit;
  assign first_hit = eval_valid_reg && clause_unsat && !first_unsat_valid_o;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg           <= IDLE;
      n_reg               <= '0;
      eval_valid_reg      <= 1'b0;
      eval_addr_reg       <= '0;
      clause_rd_en_o      <= 1'b0;
      clause_rd_addr_o    <= '0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
      sat_o               <= 1'b0;
      unsat_count_o       <= '0;
      first_unsat_valid_o <= 1'b0;
      first_unsat_addr_o  <= '0;
      range_err_o         <= 1'b0;
    end else begin
      done_o         <= 1'b0;
      eval_valid_reg <= clause_rd_en_o;
      eval_addr_reg  <= clause_rd_addr_o;

      if (eval_valid_reg) begin
        if (clause_unsat) begin
          unsat_count_o <= unsat_count_o + ONE;
          if (!first_unsat_valid_o) begin
            first_unsat_valid_o <= 1'b1;
            first_unsat_addr_o  <= eval_addr_reg;
          end
        end
        if (|lit_oob) range_err_o <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (start_i) begin
            n_reg               <= n_clamped;
            busy_o              <= 1'b1;
            sat_o               <= 1'b0;
            unsat_count_o       <= '0;
            first_unsat_valid_o <= 1'b0;
            first_unsat_addr_o  <= '0;
            range_err_o         <= 1'b0;
            if (n_clamped == '0) begin
              state_reg <= DONE;
            end else begin
              clause_rd_en_o   <= 1'b1;
              clause_rd_addr_o <= '0;
              state_reg        <= (n_clamped == ONE) ? DRAIN : SCAN;
            end
          end
        end
        SCAN: begin
          clause_rd_addr_o <= clause_rd_addr_o + 1'b1;
          if (({1'b0, clause_rd_addr_o} + TWO) == n_reg) state_reg <= DRAIN;
        end
        DRAIN: begin
          // The last address is in the table this cycle; its result lands during DONE.
          clause_rd_en_o <= 1'b0;
          state_reg      <= DONE;
        end
        DONE: begin
          done_o    <= 1'b1;
          busy_o    <= 1'b0;
          sat_o     <= !(first_unsat_valid_o || (eval_valid_reg && clause_unsat));
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

`ifdef CLAUSE_CHECK_EARLY_EXIT_EN
      if (first_hit) begin
        clause_rd_en_o <= 1'b0;
        eval_valid_reg <= 1'b0;
        done_o         <= 1'b1;
        busy_o         <= 1'b0;
        sat_o          <= 1'b0;
        state_reg      <= IDLE;
      end
`endif
    end
  end

endmodule
